xm_seq_controller: RTL and testbench

Parametrised multi-cycle sequencer for the XMakina core. It replaces the fixed controller behind the control plane and adds three things: memory wait-state handshaking on both fetch and data accesses, a retired-instruction counter, and optional multi-channel interrupt entry. It sits between the instruction decoder, which supplies the instruction class, and the datapath/register file, which consume the strobes and selects it drives.

---
 rtl/xm_ctrl_pkg.sv | 57 +++++
 rtl/xm_irq_prio.sv | 35 +++
 rtl/xm_seq_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_xm_seq_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// xm_ctrl_pkg
// Shared types and encodings for the XMakina sequencer (xm_seq_controller)
// and its interrupt priority encoder (xm_irq_prio).
//   state_e  : sequencer states
//   cls_e    : instruction class supplied by the decoder
//   ADR_*    : adrSel_o encodings (memory address source)
//   PC_*     : pcSel_o encodings (program counter source)
//   RWS_*    : regWrSel_o encodings (register file write source)
// ----------------------------------------------------------------------------
package xm_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC     = 4'd3,
    ST_MEM      = 4'd4,
    ST_WB       = 4'd5,
    ST_IRQ_PUSH = 4'd6,
    ST_IRQ_VEC  = 4'd7,
    ST_HALT     = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU      = 3'd0,
    CLS_IMM      = 3'd1,
    CLS_LOAD     = 3'd2,
    CLS_STORE    = 3'd3,
    CLS_BR_TAKEN = 3'd4,
    CLS_BR_NOT   = 3'd5,
    CLS_NOP      = 3'd6,
    CLS_ILLEGAL  = 3'd7
  } cls_e;

  // Address source
  localparam logic [1:0] ADR_PC  = 2'd0;
  localparam logic [1:0] ADR_EA  = 2'd1;
  localparam logic [1:0] ADR_SP  = 2'd2;
  localparam logic [1:0] ADR_VEC = 2'd3;

  // PC source
  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_MEM = 2'd2;

  // Register write source
  localparam logic [1:0] RWS_ALU = 2'd0;
  localparam logic [1:0] RWS_IMM = 2'd1;
  localparam logic [1:0] RWS_MEM = 2'd2;

  // True for classes that need a data-memory access after EXEC.
  function automatic logic is_mem_class(input cls_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/xm_irq_prio.sv
// ----------------------------------------------------------------------------
// xm_irq_prio
// Lowest-index-wins priority encoder for the interrupt request lines.
// Purely combinational.
// Ports:
//   req    in   IRQ_N  request lines
//   valid  out  1      at least one request is set
//   idx    out  IDX_W  index of the lowest set request (0 when none)
//   onehot out  IRQ_N  one-hot of idx (all zero when none)
// ----------------------------------------------------------------------------
module xm_irq_prio #(
  parameter int IRQ_N = 4,
  parameter int IDX_W = $clog2(IRQ_N)
) (
  input  logic [IRQ_N-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [IRQ_N-1:0] onehot
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    valid  = |req;
    idx    = '0;
    onehot = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xm_seq_controller.sv
// ----------------------------------------------------------------------------
// xm_seq_controller
// Multi-cycle sequencer for the XMakina core. Steps each instruction through
// FETCH / DECODE / EXEC (and MEM / WB for memory classes), handshakes every
// memory access with memBusy_i, counts retired instructions and, when built
// with XM_IRQ_EN defined, performs interrupt entry (push, then vector fetch)
// after a retire. Without XM_IRQ_EN, irq_i and gie_i are ignored and
// irqAck_o / vecIdx_o are tied to 0.
//
// Ports:
//   clk_i        in   1      clock, rising edge
//   arst_i       in   1      synchronous active-high reset
//   memBusy_i    in   1      memory not ready; access completes when low
//   instClass_i  in   3      decoder instruction class (cls_e)
//   flagsUpd_i   in   1      instruction updates flags
//   gie_i        in   1      global interrupt enable
//   irq_i        in   IRQ_N  level-sensitive interrupt requests
//   irWr_o, pcWr_o, regWr_o, flagsWr_o  out  register strobes
//   memEn_o, memRW_o                     out  memory enable / write
//   adrSel_o     out  2      address source (ADR_*)
//   pcSel_o      out  2      PC source (PC_*)
//   regWrSel_o   out  2      register write source (RWS_*)
//   vecIdx_o     out  IDX_W  interrupt vector index
//   irqAck_o     out  IRQ_N  one-hot acknowledge pulse
//   retire_o     out  1      retire pulse
//   retCnt_o     out  WORD   retired-instruction count (wraps)
//   illegal_o    out  1      sticky illegal-instruction halt flag
// ----------------------------------------------------------------------------
module xm_seq_controller
  import xm_ctrl_pkg::*;
#(
  parameter int WORD  = 16,
  parameter int IRQ_N = 4,
  parameter int IDX_W = $clog2(IRQ_N)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             memBusy_i,
  input  logic [2:0]       instClass_i,
  input  logic             flagsUpd_i,
  input  logic             gie_i,
  input  logic [IRQ_N-1:0] irq_i,
  output logic             irWr_o,
  output logic             pcWr_o,
  output logic             regWr_o,
  output logic             flagsWr_o,
  output logic             memEn_o,
  output logic             memRW_o,
  output logic [1:0]       adrSel_o,
  output logic [1:0]       pcSel_o,
  output logic [1:0]       regWrSel_o,
  output logic [IDX_W-1:0] vecIdx_o,
  output logic [IRQ_N-1:0] irqAck_o,
  output logic             retire_o,
  output logic [WORD-1:0]  retCnt_o,
  output logic             illegal_o
);

  localparam logic [WORD-1:0] CNT_ONE = {{(WORD-1){1'b0}}, 1'b1};

  state_e          state_q;
  cls_e            cls_q;
  logic [WORD-1:0] ret_cnt_q;
  logic            illegal_q;

`ifdef XM_IRQ_EN
  logic             prio_valid;
  logic [IDX_W-1:0] prio_idx;
  logic [IRQ_N-1:0] prio_onehot;
  logic [IDX_W-1:0] irq_idx_q;
  logic [IRQ_N-1:0] irq_oh_q;
  logic [IDX_W-1:0] vec_hold_q;

  xm_irq_prio #(
    .IRQ_N (IRQ_N),
    .IDX_W (IDX_W)
  ) u_prio (
    .req    (irq_i),
    .valid  (prio_valid),
    .idx    (prio_idx),
    .onehot (prio_onehot)
  );

  // The latched index is presented only while the vector is being fetched;
  // elsewhere the output keeps the index of the last completed entry.
  assign vecIdx_o = (state_q == ST_IRQ_VEC) ? irq_idx_q : vec_hold_q;
`else
  logic unused_irq;
  assign unused_irq = gie_i ^ (^irq_i);
  assign vecIdx_o   = '0;
  assign irqAck_o   = '0;
`endif

  assign retCnt_o  = ret_cnt_q;
  assign illegal_o = illegal_q;

  // Output decode: a function of the state and, for access states, of
  // memBusy_i so that strobes fire only in the completing cycle.
  always_comb begin
    irWr_o     = 1'b0;
    pcWr_o     = 1'b0;
    regWr_o    = 1'b0;
    flagsWr_o  = 1'b0;
    memEn_o    = 1'b0;
    memRW_o    = 1'b0;
    adrSel_o   = ADR_PC;
    pcSel_o    = PC_INC;
    regWrSel_o = RWS_ALU;
    retire_o   = 1'b0;
`ifdef XM_IRQ_EN
    irqAck_o   = '0;
`endif
    case (state_q)
      ST_FETCH: begin
        memEn_o  = 1'b1;
        adrSel_o = ADR_PC;
        if (!memBusy_i) begin
          irWr_o  = 1'b1;
          pcWr_o  = 1'b1;
          pcSel_o = PC_INC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_ALU: begin
            regWr_o    = 1'b1;
            regWrSel_o = RWS_ALU;
            flagsWr_o  = flagsUpd_i;
            retire_o   = 1'b1;
          end
          CLS_IMM: begin
            regWr_o    = 1'b1;
            regWrSel_o = RWS_IMM;
            flagsWr_o  = flagsUpd_i;
            retire_o   = 1'b1;
          end
          CLS_BR_TAKEN: begin
            pcWr_o   = 1'b1;
            pcSel_o  = PC_BR;
            retire_o = 1'b1;
          end
          CLS_BR_NOT, CLS_NOP: retire_o = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        memEn_o  = 1'b1;
        adrSel_o = ADR_EA;
        memRW_o  = (cls_q == CLS_STORE);
        // A store is finished once the write completes; a load still
        // has its write-back cycle ahead.
        if (!memBusy_i && (cls_q == CLS_STORE)) retire_o = 1'b1;
      end
      ST_WB: begin
        regWr_o    = 1'b1;
        regWrSel_o = RWS_MEM;
        flagsWr_o  = flagsUpd_i;
        retire_o   = 1'b1;
      end
`ifdef XM_IRQ_EN
      ST_IRQ_PUSH: begin
        memEn_o  = 1'b1;
        memRW_o  = 1'b1;
        adrSel_o = ADR_SP;
      end
      ST_IRQ_VEC: begin
        memEn_o  = 1'b1;
        adrSel_o = ADR_VEC;
        if (!memBusy_i) begin
          pcWr_o   = 1'b1;
          pcSel_o  = PC_MEM;
          irqAck_o = irq_oh_q;
        end
      end
`endif
      default: ;
    endcase
  end

  // Sequencer state, class latch, retire counter and sticky illegal flag.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q    <= ST_RST;
      cls_q      <= CLS_NOP;
      ret_cnt_q  <= '0;
      illegal_q  <= 1'b0;
`ifdef XM_IRQ_EN
      irq_idx_q  <= '0;
      irq_oh_q   <= '0;
      vec_hold_q <= '0;
`endif
    end else if (retire_o) begin
      ret_cnt_q <= ret_cnt_q + CNT_ONE;
`ifdef XM_IRQ_EN
      // Requests are sampled only here; the winner is latched so a request
      // dropping during entry does not disturb it.
      if (gie_i && prio_valid) begin
        state_q   <= ST_IRQ_PUSH;
        irq_idx_q <= prio_idx;
        irq_oh_q  <= prio_onehot;
      end else begin
        state_q <= ST_FETCH;
      end
`else
      state_q <= ST_FETCH;
`endif
    end else begin
      case (state_q)
        ST_RST:   state_q <= ST_FETCH;
        ST_FETCH: if (!memBusy_i) state_q <= ST_DECODE;
        ST_DECODE: begin
          // The decoder output is only trusted here; later states use the copy.
          cls_q   <= cls_e'(instClass_i);
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_mem_class(cls_q)) begin
            state_q <= ST_MEM;
          end else if (cls_q == CLS_ILLEGAL) begin
            state_q   <= ST_HALT;
            illegal_q <= 1'b1;
          end
        end
        // Only loads reach here without retiring.
        ST_MEM: if (!memBusy_i) state_q <= ST_WB;
`ifdef XM_IRQ_EN
        ST_IRQ_PUSH: if (!memBusy_i) state_q <= ST_IRQ_VEC;
        ST_IRQ_VEC: begin
          if (!memBusy_i) begin
            state_q    <= ST_FETCH;
            vec_hold_q <= irq_idx_q;
          end
        end
`endif
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_xm_seq_controller.sv
// ----------------------------------------------------------------------------
// tb_xm_seq_controller
// Directed bench for xm_seq_controller. One linear initial block drives one
// cycle at a time and compares the decoded outputs against hand-computed
// constants. WORD is set to 8 so the retire counter wrap is reachable in a
// short run. Interrupt-entry expectations follow the XM_IRQ_EN build option.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xm_seq_controller;

  localparam int WORD  = 8;
  localparam int IRQ_N = 4;
  localparam int IDX_W = 2;

  // Packed control view: {irWr,pcWr,regWr,flagsWr,memEn,memRW,adrSel,pcSel,regWrSel}
  localparam logic [11:0] C_IDLE       = 12'b000000_000000;
  localparam logic [11:0] C_FETCH_BUSY = 12'b000010_000000;
  localparam logic [11:0] C_FETCH      = 12'b110010_000000;
  localparam logic [11:0] C_ALU_F      = 12'b001100_000000;
  localparam logic [11:0] C_MEM_RD     = 12'b000010_010000;
  localparam logic [11:0] C_WB         = 12'b001000_000010;
  localparam logic [11:0] C_ST         = 12'b000011_010000;
  localparam logic [11:0] C_BRT        = 12'b010000_000100;
  localparam logic [11:0] C_IMM        = 12'b001000_000001;
  localparam logic [11:0] C_PUSH       = 12'b000011_100000;
  localparam logic [11:0] C_VEC_BUSY   = 12'b000010_110000;
  localparam logic [11:0] C_VEC        = 12'b010010_111000;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             busy = 1'b0;
  logic [2:0]       cls = 3'd6;
  logic             flags = 1'b0;
  logic             gie = 1'b0;
  logic [IRQ_N-1:0] irq = '0;

  logic             irWr, pcWr, regWr, flagsWr, memEn, memRW;
  logic [1:0]       adrSel, pcSel, regWrSel;
  logic [IDX_W-1:0] vecIdx;
  logic [IRQ_N-1:0] irqAck;
  logic             retire;
  logic [WORD-1:0]  retCnt;
  logic             illegal;
  logic [11:0]      ctl;

  int               checks;
  int               errors;
  logic [WORD-1:0]  exp_cnt;
  logic [IDX_W-1:0] exp_vec;

  assign ctl = {irWr, pcWr, regWr, flagsWr, memEn, memRW, adrSel, pcSel, regWrSel};

  always #5 clk = ~clk;

  xm_seq_controller #(
    .WORD  (WORD),
    .IRQ_N (IRQ_N),
    .IDX_W (IDX_W)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .memBusy_i   (busy),
    .instClass_i (cls),
    .flagsUpd_i  (flags),
    .gie_i       (gie),
    .irq_i       (irq),
    .irWr_o      (irWr),
    .pcWr_o      (pcWr),
    .regWr_o     (regWr),
    .flagsWr_o   (flagsWr),
    .memEn_o     (memEn),
    .memRW_o     (memRW),
    .adrSel_o    (adrSel),
    .pcSel_o     (pcSel),
    .regWrSel_o  (regWrSel),
    .vecIdx_o    (vecIdx),
    .irqAck_o    (irqAck),
    .retire_o    (retire),
    .retCnt_o    (retCnt),
    .illegal_o   (illegal)
  );

  // Advance to the next cycle, apply that cycle's inputs, let outputs settle.
  task automatic cyc(input logic r, input logic b, input logic [2:0] c,
                     input logic f, input logic g, input logic [IRQ_N-1:0] q);
    @(posedge clk);
    #1;
    arst  = r;
    busy  = b;
    cls   = c;
    flags = f;
    gie   = g;
    irq   = q;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    exp_vec = '0;

    // Reset applied at the first edge: this cycle is RST
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("rst_ctl", ctl, C_IDLE);
    chk("rst_cnt", retCnt, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_ack", irqAck, 0);
    chk("rst_vec", vecIdx, 0);
    chk("rst_retire", retire, 0);

    // ALU with flag update, no wait states
    cyc(0, 0, 3'd0, 1, 0, 4'b0000);
    chk("alu_fetch", ctl, C_FETCH);
    chk("alu_cnt0", retCnt, exp_cnt);
    cyc(0, 0, 3'd0, 1, 0, 4'b0000);
    chk("alu_decode", ctl, C_IDLE);
    cyc(0, 0, 3'd0, 1, 0, 4'b0000);
    chk("alu_exec", ctl, C_ALU_F);
    chk("alu_retire", retire, 1);
    exp_cnt++;

    // LOAD: 2 busy fetch cycles, 3 busy data cycles; class changes after DECODE
    cyc(0, 1, 3'd2, 0, 0, 4'b0000);
    chk("ld_fetch_busy1", ctl, C_FETCH_BUSY);
    chk("alu_cnt1", retCnt, exp_cnt);
    cyc(0, 1, 3'd2, 0, 0, 4'b0000);
    chk("ld_fetch_busy2", ctl, C_FETCH_BUSY);
    cyc(0, 0, 3'd2, 0, 0, 4'b0000);
    chk("ld_fetch_done", ctl, C_FETCH);
    cyc(0, 0, 3'd2, 0, 0, 4'b0000);
    chk("ld_decode", ctl, C_IDLE);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("ld_exec", ctl, C_IDLE);
    chk("ld_exec_retire", retire, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 3'd6, 0, 0, 4'b0000);
      chk("ld_mem_busy", ctl, C_MEM_RD);
    end
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("ld_mem_done", ctl, C_MEM_RD);
    chk("ld_mem_retire", retire, 0);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("ld_wb", ctl, C_WB);
    chk("ld_wb_retire", retire, 1);
    exp_cnt++;

    // STORE
    cyc(0, 0, 3'd3, 0, 0, 4'b0000);
    chk("st_fetch", ctl, C_FETCH);
    chk("ld_cnt", retCnt, exp_cnt);
    cyc(0, 0, 3'd3, 0, 0, 4'b0000);
    cyc(0, 0, 3'd3, 0, 0, 4'b0000);
    chk("st_exec", ctl, C_IDLE);
    cyc(0, 0, 3'd3, 0, 0, 4'b0000);
    chk("st_mem", ctl, C_ST);
    chk("st_retire", retire, 1);
    exp_cnt++;

    // Taken branch
    cyc(0, 0, 3'd4, 0, 0, 4'b0000);
    chk("brt_fetch", ctl, C_FETCH);
    cyc(0, 0, 3'd4, 0, 0, 4'b0000);
    cyc(0, 0, 3'd4, 0, 0, 4'b0000);
    chk("brt_exec", ctl, C_BRT);
    chk("brt_retire", retire, 1);
    exp_cnt++;

    // Immediate without flag update
    cyc(0, 0, 3'd1, 0, 0, 4'b0000);
    chk("imm_fetch", ctl, C_FETCH);
    chk("brt_cnt", retCnt, exp_cnt);
    cyc(0, 0, 3'd1, 0, 0, 4'b0000);
    cyc(0, 0, 3'd1, 0, 0, 4'b0000);
    chk("imm_exec", ctl, C_IMM);
    exp_cnt++;

    // Branch not taken, all requests up but interrupts disabled
    cyc(0, 0, 3'd5, 0, 0, 4'b1111);
    chk("brn_fetch", ctl, C_FETCH);
    cyc(0, 0, 3'd5, 0, 0, 4'b1111);
    cyc(0, 0, 3'd5, 0, 0, 4'b1111);
    chk("brn_exec", ctl, C_IDLE);
    chk("brn_retire", retire, 1);
    exp_cnt++;

    // NOP retiring with gie=1, irq=0110
    cyc(0, 0, 3'd6, 0, 1, 4'b0110);
    chk("gie0_no_entry", ctl, C_FETCH);
    chk("gie0_ack", irqAck, 0);
    cyc(0, 0, 3'd6, 0, 1, 4'b0110);
    cyc(0, 0, 3'd6, 0, 1, 4'b0110);
    chk("irqnop_retire", retire, 1);
    exp_cnt++;
`ifdef XM_IRQ_EN
    // Requests drop immediately; entry proceeds with the latched index 1
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("push_ctl", ctl, C_PUSH);
    chk("push_vec", vecIdx, 0);
    chk("push_ack", irqAck, 0);
    cyc(0, 1, 3'd6, 0, 0, 4'b0000);
    chk("vec_busy_ctl", ctl, C_VEC_BUSY);
    chk("vec_busy_idx", vecIdx, 1);
    chk("vec_busy_ack", irqAck, 0);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("vec_ctl", ctl, C_VEC);
    chk("vec_idx", vecIdx, 1);
    chk("vec_ack", irqAck, 4'b0010);
    exp_vec = 2'd1;
`endif

    // Back to FETCH, then NOPs up to the counter limit
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("post_irq_fetch", ctl, C_FETCH);
    chk("post_irq_ack", irqAck, 0);
    chk("post_irq_vec", vecIdx, exp_vec);
    chk("post_irq_cnt", retCnt, exp_cnt);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    exp_cnt++;
    for (int i = 0; i < 247; i++) begin
      cyc(0, 0, 3'd6, 0, 0, 4'b0000);
      cyc(0, 0, 3'd6, 0, 0, 4'b0000);
      cyc(0, 0, 3'd6, 0, 0, 4'b0000);
      exp_cnt++;
    end
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("cnt_max", retCnt, 8'hFF);
    chk("cnt_model", retCnt, exp_cnt);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    cyc(0, 0, 3'd6, 0, 0, 4'b0000);
    chk("wrap_retire", retire, 1);
    exp_cnt++;

    // LOAD, reset asserted during a busy data access
    cyc(0, 0, 3'd2, 0, 0, 4'b0000);
    chk("cnt_wrap", retCnt, 0);
    chk("rm_fetch", ctl, C_FETCH);
    cyc(0, 0, 3'd2, 0, 0, 4'b0000);
    cyc(0, 0, 3'd2, 0, 0, 4'b0000);
    cyc(1, 1, 3'd2, 0, 0, 4'b0000);
    chk("rm_mem_busy", ctl, C_MEM_RD);
    cyc(0, 1, 3'd2, 0, 0, 4'b0000);
    chk("rm_rst_ctl", ctl, C_IDLE);
    chk("rm_rst_memen", memEn, 0);
    exp_cnt = '0;

    // ILLEGAL halts the core until reset
    cyc(0, 0, 3'd7, 0, 0, 4'b0000);
    chk("il_fetch", ctl, C_FETCH);
    cyc(0, 0, 3'd7, 0, 0, 4'b0000);
    cyc(0, 0, 3'd7, 0, 0, 4'b0000);
    chk("il_exec", ctl, C_IDLE);
    chk("il_exec_retire", retire, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 3'd0, 1, 0, 4'b0000);
      chk("halt_ctl", ctl, C_IDLE);
      chk("halt_ill", illegal, 1);
    end
    cyc(1, 0, 3'd0, 1, 0, 4'b0000);
    chk("halt_ill_pre_rst", illegal, 1);
    cyc(0, 0, 3'd0, 0, 0, 4'b0000);
    chk("il_rst_ill", illegal, 0);
    chk("il_rst_ctl", ctl, C_IDLE);
    chk("il_rst_cnt", retCnt, exp_cnt);
    cyc(0, 0, 3'd0, 0, 0, 4'b0000);
    chk("il_resume_fetch", ctl, C_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
